// File: rtl/regfile16_if.sv
// Register-file bus: ALU write-back, two read ports, load issue/return and scoreboard outputs.
// Master drives requests; the register file (slave) answers reads, pending, stall and err.
interface regfile16_if #(
    parameter int WIDTH = 16
);
    logic             wr_en;
    logic [3:0]       wr_sel;
    logic [WIDTH-1:0] wr_data;
    logic [3:0]       rd_sel_a;
    logic [3:0]       rd_sel_b;
    logic             rd_use_a;
    logic             rd_use_b;
    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;
    logic             ld_issue;
    logic [3:0]       ld_sel;
    logic             ld_ret;
    logic [3:0]       ld_ret_sel;
    logic [WIDTH-1:0] ld_data;
    logic [15:0]      pending;
    logic             stall;
    logic             err;

    modport master (
        output wr_en, wr_sel, wr_data,
        output rd_sel_a, rd_sel_b, rd_use_a, rd_use_b,
        output ld_issue, ld_sel, ld_ret, ld_ret_sel, ld_data,
        input  rd_data_a, rd_data_b, pending, stall, err
    );

    modport slave (
        input  wr_en, wr_sel, wr_data,
        input  rd_sel_a, rd_sel_b, rd_use_a, rd_use_b,
        input  ld_issue, ld_sel, ld_ret, ld_ret_sel, ld_data,
        output rd_data_a, rd_data_b, pending, stall, err
    );
endinterface

// File: rtl/regfile16.sv
// 16x16 register file with load scoreboard; writes visible 1 cycle after the edge, reads combinational.
// Backpressure: combinational stall when an operand, ALU destination or load destination is pending.
module regfile16 #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    regfile16_if.slave bus
);
    logic [WIDTH-1:0] regs [16];
    logic [15:0]      pending;
    logic             err;

    logic [15:0] we_alu;
    logic [15:0] we_ld;
    logic [15:0] ld_set;
    logic        wr_en_ok;
    logic        ld_ret_ok;
    logic        ld_issue_ok;

    assign wr_en_ok  = bus.wr_en & ~pending[bus.wr_sel];
    assign ld_ret_ok = bus.ld_ret & pending[bus.ld_ret_sel];
    // A return and a fresh issue to the same register re-arm it: the new issue wins over the clear.
    assign ld_issue_ok = bus.ld_issue &
                         (~pending[bus.ld_sel] | (ld_ret_ok & (bus.ld_ret_sel == bus.ld_sel)));

    dmux4x16 u_wr_dmux  (.en(wr_en_ok),    .sel(bus.wr_sel),     .y(we_alu));
    dmux4x16 u_ld_dmux  (.en(ld_ret_ok),   .sel(bus.ld_ret_sel), .y(we_ld));
    dmux4x16 u_set_dmux (.en(ld_issue_ok), .sel(bus.ld_sel),     .y(ld_set));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 16; n++) begin
                regs[n] <= '0;
            end
            pending <= '0;
            err     <= 1'b0;
        end else begin
            for (int n = 0; n < 16; n++) begin
                if (we_ld[n]) begin
                    regs[n] <= bus.ld_data;
                end else if (we_alu[n]) begin
                    regs[n] <= bus.wr_data;
                end
            end
            pending <= (pending & ~we_ld) | ld_set;
            if (bus.ld_ret & ~pending[bus.ld_ret_sel]) begin
                err <= 1'b1;
            end
        end
    end

    assign bus.rd_data_a = regs[bus.rd_sel_a];
    assign bus.rd_data_b = regs[bus.rd_sel_b];
    assign bus.pending   = pending;
    assign bus.err       = err;
    assign bus.stall     = (bus.rd_use_a & pending[bus.rd_sel_a]) |
                           (bus.rd_use_b & pending[bus.rd_sel_b]) |
                           (bus.wr_en    & pending[bus.wr_sel])   |
                           (bus.ld_issue & pending[bus.ld_sel]);
endmodule

module dmux4x16 (
    input  logic        en,
    input  logic [3:0]  sel,
    output logic [15:0] y
);
    assign y = en ? (16'h0001 << sel) : 16'h0000;
endmodule

// File: tb/tb_regfile16.sv
// Directed bench for regfile16: expectations queued when stimulus is driven, popped and checked once outputs settle.
module tb_regfile16;
    localparam int K_RDA = 0, K_RDB = 1, K_PEND = 2, K_STALL = 3, K_ERR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    string       q_tag  [$];
    int          q_kind [$];
    logic [31:0] q_val  [$];

    regfile16_if #(.WIDTH(16)) bus ();
    regfile16 #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic idle();
        bus.wr_en = 1'b0; bus.wr_sel = 4'd0; bus.wr_data = 16'h0;
        bus.rd_sel_a = 4'd0; bus.rd_sel_b = 4'd0; bus.rd_use_a = 1'b0; bus.rd_use_b = 1'b0;
        bus.ld_issue = 1'b0; bus.ld_sel = 4'd0; bus.ld_ret = 1'b0; bus.ld_ret_sel = 4'd0;
        bus.ld_data = 16'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input int kind, input logic [31:0] v);
        q_tag.push_back(tag);
        q_kind.push_back(kind);
        q_val.push_back(v);
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_RDA:   return {16'h0, bus.rd_data_a};
            K_RDB:   return {16'h0, bus.rd_data_b};
            K_PEND:  return {16'h0, bus.pending};
            K_STALL: return {31'h0, bus.stall};
            default: return {31'h0, bus.err};
        endcase
    endfunction

    // Let combinational outputs settle, then drain the scoreboard.
    task automatic check();
        string       tag;
        int          kind;
        logic [31:0] exp_v;
        logic [31:0] obs_v;
        #1;
        while (q_tag.size() > 0) begin
            tag   = q_tag.pop_front();
            kind  = q_kind.pop_front();
            exp_v = q_val.pop_front();
            obs_v = observe(kind);
            vectors++;
            assert (obs_v === exp_v) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        bus.rd_sel_b = 4'd15;
        expect_val("rst_pending", K_PEND, 32'h0);
        expect_val("rst_err", K_ERR, 32'h0);
        expect_val("rst_stall", K_STALL, 32'h0);
        expect_val("rst_rda", K_RDA, 32'h0);
        expect_val("rst_rdb", K_RDB, 32'h0);
        check();

        // Basic write: no bypass, visible next cycle
        bus.wr_en = 1'b1; bus.wr_sel = 4'd5; bus.wr_data = 16'h1234; bus.rd_sel_a = 4'd5;
        expect_val("wr5_same_cycle", K_RDA, 32'h0);
        check();
        tick();
        idle(); bus.rd_sel_a = 4'd5;
        expect_val("wr5_next_cycle", K_RDA, 32'h1234);
        expect_val("wr5_stall", K_STALL, 32'h0);
        check();

        // Sweep: each write touches only its own register
        for (int n = 0; n < 16; n++) begin
            idle();
            bus.wr_en = 1'b1; bus.wr_sel = 4'(n); bus.wr_data = 16'hA000 + 16'(n);
            tick();
            idle();
            bus.rd_sel_a = 4'(n);
            bus.rd_sel_b = 4'((n + 1) % 16);
            expect_val("sweep_written", K_RDA, 32'hA000 + 32'(n));
            if (n == 15)
                expect_val("sweep_neighbour", K_RDB, 32'hA000);
            else if (n == 4)
                expect_val("sweep_neighbour", K_RDB, 32'h1234);
            else
                expect_val("sweep_neighbour", K_RDB, 32'h0);
            check();
        end
        for (int n = 0; n < 16; n++) begin
            bus.rd_sel_a = 4'(n);
            bus.rd_sel_b = 4'(15 - n);
            expect_val("sweep_read_a", K_RDA, 32'hA000 + 32'(n));
            expect_val("sweep_read_b", K_RDB, 32'hA000 + 32'(15 - n));
            check();
        end

        // Load dependency on R3
        idle();
        bus.ld_issue = 1'b1; bus.ld_sel = 4'd3;
        expect_val("ld3_issue_stall", K_STALL, 32'h0);
        check();
        tick();
        idle();
        expect_val("ld3_pending", K_PEND, 32'h0008);
        check();
        for (int c = 0; c < 3; c++) begin
            idle();
            bus.rd_use_a = 1'b1; bus.rd_sel_a = 4'd3;
            if (c == 2) begin
                bus.ld_ret = 1'b1; bus.ld_ret_sel = 4'd3; bus.ld_data = 16'hBEEF;
            end
            expect_val("ld3_dep_stall", K_STALL, 32'h1);
            expect_val("ld3_stale_read", K_RDA, 32'hA003);
            check();
            tick();
        end
        idle();
        bus.rd_use_a = 1'b1; bus.rd_sel_a = 4'd3;
        expect_val("ld3_ret_stall", K_STALL, 32'h0);
        expect_val("ld3_ret_data", K_RDA, 32'hBEEF);
        expect_val("ld3_ret_pending", K_PEND, 32'h0);
        expect_val("ld3_err", K_ERR, 32'h0);
        check();

        // Conflict: ALU write and load return on pending R7
        idle();
        bus.ld_issue = 1'b1; bus.ld_sel = 4'd7;
        tick();
        idle();
        bus.wr_en = 1'b1; bus.wr_sel = 4'd7; bus.wr_data = 16'h1111;
        bus.ld_ret = 1'b1; bus.ld_ret_sel = 4'd7; bus.ld_data = 16'h2222;
        expect_val("r7_wr_ret_stall", K_STALL, 32'h1);
        expect_val("r7_wr_ret_pend_before", K_PEND, 32'h0080);
        check();
        tick();
        idle(); bus.rd_sel_a = 4'd7;
        expect_val("r7_wr_ret_data", K_RDA, 32'h2222);
        expect_val("r7_wr_ret_pend", K_PEND, 32'h0);
        check();

        // Conflict: load return and new issue on R7 keeps it pending
        bus.ld_issue = 1'b1; bus.ld_sel = 4'd7;
        tick();
        idle();
        bus.ld_ret = 1'b1; bus.ld_ret_sel = 4'd7; bus.ld_data = 16'h3333;
        bus.ld_issue = 1'b1; bus.ld_sel = 4'd7;
        expect_val("r7_ret_iss_stall", K_STALL, 32'h1);
        check();
        tick();
        idle(); bus.rd_sel_a = 4'd7;
        expect_val("r7_ret_iss_pend", K_PEND, 32'h0080);
        expect_val("r7_ret_iss_data", K_RDA, 32'h3333);
        check();
        bus.ld_ret = 1'b1; bus.ld_ret_sel = 4'd7; bus.ld_data = 16'h4444;
        tick();
        idle(); bus.rd_sel_a = 4'd7;
        expect_val("r7_final_data", K_RDA, 32'h4444);
        expect_val("r7_final_pend", K_PEND, 32'h0);
        expect_val("r7_final_err", K_ERR, 32'h0);
        check();

        // Independent events on different registers
        bus.wr_en = 1'b1; bus.wr_sel = 4'd9; bus.wr_data = 16'h9999;
        bus.ld_issue = 1'b1; bus.ld_sel = 4'd10;
        expect_val("indep_stall", K_STALL, 32'h0);
        check();
        tick();
        idle(); bus.rd_sel_a = 4'd9;
        expect_val("indep_r9", K_RDA, 32'h9999);
        expect_val("indep_pend", K_PEND, 32'h0400);
        check();
        bus.ld_ret = 1'b1; bus.ld_ret_sel = 4'd10; bus.ld_data = 16'h1010;
        bus.wr_en = 1'b1; bus.wr_sel = 4'd11; bus.wr_data = 16'h1111;
        tick();
        idle(); bus.rd_sel_a = 4'd10; bus.rd_sel_b = 4'd11;
        expect_val("indep_r10", K_RDA, 32'h1010);
        expect_val("indep_r11", K_RDB, 32'h1111);
        expect_val("indep_pend_clr", K_PEND, 32'h0);
        check();

        // ALU write plus issue to the same free register: both take effect
        bus.wr_en = 1'b1; bus.wr_sel = 4'd12; bus.wr_data = 16'h0C0C;
        bus.ld_issue = 1'b1; bus.ld_sel = 4'd12;
        expect_val("wr_iss_stall", K_STALL, 32'h0);
        check();
        tick();
        idle(); bus.rd_sel_a = 4'd12;
        expect_val("wr_iss_data", K_RDA, 32'h0C0C);
        expect_val("wr_iss_pend", K_PEND, 32'h1000);
        check();
        bus.ld_ret = 1'b1; bus.ld_ret_sel = 4'd12; bus.ld_data = 16'hCCCC;
        tick();
        idle();
        expect_val("wr_iss_pend_clr", K_PEND, 32'h0);
        check();

        // Reset with loads outstanding, overriding a same-cycle write
        bus.ld_issue = 1'b1; bus.ld_sel = 4'd1;
        tick();
        bus.ld_sel = 4'd2;
        tick();
        idle();
        expect_val("mid_pend", K_PEND, 32'h0006);
        check();
        rst = 1'b1;
        bus.wr_en = 1'b1; bus.wr_sel = 4'd4; bus.wr_data = 16'hFFFF;
        tick();
        rst = 1'b0;
        idle();
        expect_val("mid_rst_pend", K_PEND, 32'h0);
        expect_val("mid_rst_err", K_ERR, 32'h0);
        check();
        for (int n = 0; n < 16; n++) begin
            bus.rd_sel_a = 4'(n);
            bus.rd_sel_b = 4'(n);
            expect_val("mid_rst_reg_a", K_RDA, 32'h0);
            expect_val("mid_rst_reg_b", K_RDB, 32'h0);
            check();
        end

        // Orphaned return sets sticky err and writes nothing
        idle();
        bus.ld_ret = 1'b1; bus.ld_ret_sel = 4'd1; bus.ld_data = 16'h5555;
        expect_val("orphan_stall", K_STALL, 32'h0);
        check();
        tick();
        idle(); bus.rd_sel_a = 4'd1;
        expect_val("orphan_err", K_ERR, 32'h1);
        expect_val("orphan_r1", K_RDA, 32'h0);
        expect_val("orphan_pend", K_PEND, 32'h0);
        check();
        tick();
        tick();
        expect_val("err_sticky", K_ERR, 32'h1);
        check();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_val("err_cleared", K_ERR, 32'h0);
        check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
